// File: rtl/play_timer.sv
// Elapsed-play timer: prescaled 1 s tick driving three BCD digits M:SS (0:00..9:59).
// Optional feature macro TIMER_SATURATE_EN: hold at 9:59 instead of wrapping to 0:00.
module play_timer #(
    parameter int TICKS_PER_SECOND = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count,
    output logic [3:0] seconds0,
    output logic [3:0] seconds1,
    output logic [3:0] minutes0
);

    localparam int PW = (TICKS_PER_SECOND > 1) ? $clog2(TICKS_PER_SECOND) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SECOND - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    s0_q, s0_d, s1_q, s1_d, m0_q, m0_d;
    logic          at_max, run, tick;

    assign at_max = (m0_q == 4'd9) && (s1_q == 4'd5) && (s0_q == 4'd9);

`ifdef TIMER_SATURATE_EN
    // Once 9:59 is reached the whole timer, prescaler included, freezes until reset.
    assign run = count && !at_max;
`else
    assign run = count;
`endif

    assign tick = run && (presc_q == PMAX);

    always_comb begin
        presc_d = presc_q;
        if (run)
            presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
    end

    always_comb begin
        s0_d = s0_q;
        s1_d = s1_q;
        m0_d = m0_q;
        if (tick) begin
            if (at_max) begin
                s0_d = 4'd0;
                s1_d = 4'd0;
                m0_d = 4'd0;
            end else if (s0_q == 4'd9) begin
                s0_d = 4'd0;
                if (s1_q == 4'd5) begin
                    s1_d = 4'd0;
                    m0_d = m0_q + 4'd1;
                end else begin
                    s1_d = s1_q + 4'd1;
                end
            end else begin
                s0_d = s0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            s0_q    <= 4'd0;
            s1_q    <= 4'd0;
            m0_q    <= 4'd0;
        end else begin
            presc_q <= presc_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            m0_q    <= m0_d;
        end
    end

    assign seconds0 = s0_q;
    assign seconds1 = s1_q;
    assign minutes0 = m0_q;

endmodule

// File: tb/tb_play_timer.sv
// Bench for play_timer: TPS=1 and TPS=4 instances checked against a seconds-count scoreboard.
module tb_play_timer;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0, rst_b = 1'b0;
    logic       cnt_a = 1'b0, cnt_b = 1'b0;
    logic [3:0] s0_a, s1_a, m0_a, s0_b, s1_b, m0_b;

    play_timer #(.TICKS_PER_SECOND(1)) dut_a (
        .clk(clk), .reset(rst_a), .count(cnt_a),
        .seconds0(s0_a), .seconds1(s1_a), .minutes0(m0_a));

    play_timer #(.TICKS_PER_SECOND(4)) dut_b (
        .clk(clk), .reset(rst_b), .count(cnt_b),
        .seconds0(s0_b), .seconds1(s1_b), .minutes0(m0_b));

    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        logic [11:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  passed = 0, total = 0;
    int  presc_a = 0, secs_a = 0, presc_b = 0, secs_b = 0;

    function automatic logic [11:0] to_bcd(input int secs);
        logic [3:0] m, t, u;
        m = 4'(secs / 60);
        t = 4'((secs % 60) / 10);
        u = 4'(secs % 10);
        return {m, t, u};
    endfunction

    function automatic void model_edge(input int tps, input logic rst, input logic cnt,
                                       inout int presc, inout int secs);
        if (!rst) begin
            presc = 0;
            secs  = 0;
            return;
        end
`ifdef TIMER_SATURATE_EN
        if (secs == 599) return;
`endif
        if (!cnt) return;
        if (presc == tps - 1) begin
            presc = 0;
            secs  = (secs + 1) % 600;
        end else begin
            presc++;
        end
    endfunction

    // One rising edge: predict both instances, then compare after the edge.
    task automatic step();
        sb_t e, p;
        logic [11:0] got;
        model_edge(1, rst_a, cnt_a, presc_a, secs_a);
        e.inst = 0; e.exp = to_bcd(secs_a); sb_q.push_back(e);
        model_edge(4, rst_b, cnt_b, presc_b, secs_b);
        e.inst = 1; e.exp = to_bcd(secs_b); sb_q.push_back(e);
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            got = (p.inst == 0) ? {m0_a, s1_a, s0_a} : {m0_b, s1_b, s0_b};
            total++;
            if (got !== p.exp)
                $display("FAIL sb_inst%0d t=%0t got %h expected %h", p.inst, $time, got, p.exp);
            else
                passed++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h000)
            $display("FAIL reset_initial got %h expected 000", {m0_a, s1_a, s0_a});
        else passed++;
        cnt_a = 1'b1;
        cnt_b = 1'b1;
        steps(5);
    endtask

    task automatic test_run();
        @(negedge clk);
        rst_a = 1'b1;
        steps(10);
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h010)
            $display("FAIL run_0_10 got %h expected 010", {m0_a, s1_a, s0_a});
        else passed++;
        steps(49);
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h059)
            $display("FAIL run_0_59 got %h expected 059", {m0_a, s1_a, s0_a});
        else passed++;
    endtask

    task automatic test_carry();
        step();
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h100)
            $display("FAIL carry_1_00 got %h expected 100", {m0_a, s1_a, s0_a});
        else passed++;
    endtask

    task automatic test_pause();
        steps(40);
        @(negedge clk);
        cnt_a = 1'b0;
        steps(100);
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h140)
            $display("FAIL pause_hold got %h expected 140", {m0_a, s1_a, s0_a});
        else passed++;
        @(negedge clk);
        cnt_a = 1'b1;
        step();
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h141)
            $display("FAIL pause_resume got %h expected 141", {m0_a, s1_a, s0_a});
        else passed++;
    endtask

    task automatic test_wrap();
        steps(599 - 101);
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h959)
            $display("FAIL wrap_9_59 got %h expected 959", {m0_a, s1_a, s0_a});
        else passed++;
`ifdef TIMER_SATURATE_EN
        steps(20);
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h959)
            $display("FAIL saturate_hold got %h expected 959", {m0_a, s1_a, s0_a});
        else passed++;
`else
        step();
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h000)
            $display("FAIL wrap_0_00 got %h expected 000", {m0_a, s1_a, s0_a});
        else passed++;
`endif
    endtask

    task automatic test_async_reset();
        rst_a = 1'b0;
        steps(1);
        @(negedge clk);
        rst_a = 1'b1;
        steps(207);
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h327)
            $display("FAIL areset_3_27 got %h expected 327", {m0_a, s1_a, s0_a});
        else passed++;
        #2;
        rst_a = 1'b0;
        #1;
        presc_a = 0;
        secs_a  = 0;
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h000)
            $display("FAIL areset_clear got %h expected 000", {m0_a, s1_a, s0_a});
        else passed++;
        steps(2);
        @(negedge clk);
        rst_a = 1'b1;
        steps(3);
        total++;
        if ({m0_a, s1_a, s0_a} !== 12'h003)
            $display("FAIL areset_restart got %h expected 003", {m0_a, s1_a, s0_a});
        else passed++;
    endtask

    task automatic test_prescaler();
        @(negedge clk);
        rst_b = 1'b0;
        cnt_b = 1'b1;
        step();
        @(negedge clk);
        rst_b = 1'b1;
        steps(3);
        total++;
        if (s0_b !== 4'd0)
            $display("FAIL tps4_edge3 got %0d expected 0", s0_b);
        else passed++;
        step();
        total++;
        if (s0_b !== 4'd1)
            $display("FAIL tps4_edge4 got %0d expected 1", s0_b);
        else passed++;
        steps(4);
        total++;
        if (s0_b !== 4'd2)
            $display("FAIL tps4_edge8 got %0d expected 2", s0_b);
        else passed++;
        // Pause after edge 6 of a fresh run; partial second must survive.
        @(negedge clk);
        rst_b = 1'b0;
        step();
        @(negedge clk);
        rst_b = 1'b1;
        steps(6);
        @(negedge clk);
        cnt_b = 1'b0;
        steps(10);
        @(negedge clk);
        cnt_b = 1'b1;
        step();
        total++;
        if (s0_b !== 4'd1)
            $display("FAIL tps4_resume1 got %0d expected 1", s0_b);
        else passed++;
        step();
        total++;
        if (s0_b !== 4'd2)
            $display("FAIL tps4_resume2 got %0d expected 2", s0_b);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_run();
        test_carry();
        test_pause();
        test_wrap();
        test_async_reset();
        test_prescaler();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
